// File: rtl/pixel_axis_packer.sv
// Packs Hawk/Owl camera pixels into 64-bit AXI4-Stream beats.
// A FIFO absorbs DMA backpressure and the last beat of a frame carries tlast.
module pixel_axis_packer #(
   parameter int FIFO_DEPTH = 512,
   localparam int AW = $clog2(FIFO_DEPTH)
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        frame_rst,
   input  logic        data_sel,
   input  logic [47:0] data_in,
   input  logic        data_vld,
   input  logic        data_end,
   output logic [63:0] m_tdata,
   output logic [7:0]  m_tkeep,
   output logic        m_tlast,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        overflow,
   output logic [31:0] beat_count
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   typedef struct packed {
      logic        last;
      logic        half;
      logic [63:0] data;
   } entry_t;

   localparam int CW = AW + 1;
   localparam int FW = AW + 2;
   localparam logic [FW-1:0] DEPTH_W = FW'(FIFO_DEPTH);

   state_t      state_q, state_d;
   logic        mode_q;
   logic        lane_half_q, lane_half_d;
   logic [23:0] lo_q, lo_d;
   logic [63:0] stg_q, stg_d;
   logic        stg_vld_q, stg_vld_d;

   logic        pix, endp, complete, end_half;
   logic        eff_vld;
   logic [63:0] new_beat, eff_beat, part_beat;
   entry_t      w0, w1;
   logic        w0v, w1v;

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] mem_cnt;
   logic [FW-1:0] total, free;
   logic          pop, load, acc0, acc1, drop;
   logic          out_vld, out_last;
   logic [63:0]   out_data;
   logic [7:0]    out_keep;
   entry_t        mem [FIFO_DEPTH];

   assign pix  = (state_q == ACTIVE) && data_vld && !frame_rst;
   assign endp = (state_q == ACTIVE) && data_end && !frame_rst;
   assign complete = pix && (mode_q || lane_half_q);

   assign new_beat = mode_q ? {16'h0, data_in}
                            : {8'h0, data_in[23:0], 8'h0, lo_q};
   assign part_beat = {40'h0, lo_q};
   assign eff_vld  = complete || stg_vld_q;
   assign eff_beat = complete ? new_beat : stg_q;

   always_comb begin
      state_d     = state_q;
      lane_half_d = lane_half_q;
      lo_d        = lo_q;
      stg_d       = stg_q;
      stg_vld_d   = stg_vld_q;
      if (pix && !mode_q) begin
         lane_half_d = ~lane_half_q;
         if (!lane_half_q) lo_d = data_in[23:0];
      end
      if (complete) begin
         stg_d     = new_beat;
         stg_vld_d = 1'b1;
      end
      end_half = endp && !mode_q && lane_half_d;
      if (endp) begin
         state_d     = IDLE;
         stg_vld_d   = 1'b0;
         lane_half_d = 1'b0;
      end
      if (frame_rst) state_d = ACTIVE;
   end

   // Push slots are compacted: slot 1 is only used when slot 0 is.
   always_comb begin
      w0v = 1'b0;
      w1v = 1'b0;
      w0  = '0;
      w1  = '0;
      if (end_half) begin
         w0v = 1'b1;
         if (eff_vld) begin
            w0  = '{last: 1'b0, half: 1'b0, data: eff_beat};
            w1v = 1'b1;
            w1  = '{last: 1'b1, half: 1'b1, data: part_beat};
         end else begin
            w0  = '{last: 1'b1, half: 1'b1, data: part_beat};
         end
      end else if (complete && stg_vld_q) begin
         w0v = 1'b1;
         w0  = '{last: 1'b0, half: 1'b0, data: stg_q};
         w1v = endp;
         w1  = '{last: 1'b1, half: 1'b0, data: new_beat};
      end else if (endp && eff_vld) begin
         w0v = 1'b1;
         w0  = '{last: 1'b1, half: 1'b0, data: eff_beat};
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= IDLE;
         mode_q      <= 1'b0;
         lane_half_q <= 1'b0;
         lo_q        <= '0;
         stg_q       <= '0;
         stg_vld_q   <= 1'b0;
      end else if (frame_rst) begin
         state_q     <= state_d;
         mode_q      <= data_sel;
         lane_half_q <= 1'b0;
         lo_q        <= '0;
         stg_q       <= '0;
         stg_vld_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         lane_half_q <= lane_half_d;
         lo_q        <= lo_d;
         stg_q       <= stg_d;
         stg_vld_q   <= stg_vld_d;
      end
   end

   // Capacity counts the output register, so a pop frees a slot this cycle.
   assign pop   = out_vld && m_tready;
   assign total = FW'(mem_cnt) + FW'(out_vld);
   assign free  = DEPTH_W - total + FW'(pop);
   assign acc0  = w0v && (free >= FW'(1));
   assign acc1  = w1v && (free >= FW'(2));
   assign drop  = (w0v && !acc0) || (w1v && !acc1);
   assign load  = (!out_vld || pop) && (mem_cnt != '0);

   always_ff @(posedge sys_clk) begin
      if (acc0) mem[wr_ptr] <= w0;
      if (acc1) mem[wr_ptr + AW'(1)] <= w1;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         mem_cnt    <= '0;
         out_vld    <= 1'b0;
         out_data   <= '0;
         out_keep   <= '0;
         out_last   <= 1'b0;
         overflow   <= 1'b0;
         beat_count <= '0;
      end else if (frame_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         mem_cnt    <= '0;
         out_vld    <= 1'b0;
         out_data   <= '0;
         out_keep   <= '0;
         out_last   <= 1'b0;
         overflow   <= 1'b0;
         beat_count <= '0;
      end else begin
         wr_ptr  <= wr_ptr + AW'(acc0) + AW'(acc1);
         rd_ptr  <= rd_ptr + AW'(load);
         mem_cnt <= mem_cnt + CW'(acc0) + CW'(acc1) - CW'(load);
         if (drop) overflow <= 1'b1;
         if (pop) beat_count <= beat_count + 32'd1;
         if (load) begin
            out_vld  <= 1'b1;
            out_data <= mem[rd_ptr].data;
            out_last <= mem[rd_ptr].last;
            out_keep <= mem[rd_ptr].half ? 8'h0F : 8'hFF;
         end else if (pop) begin
            out_vld <= 1'b0;
         end
      end
   end

   assign m_tvalid = out_vld;
   assign m_tdata  = out_data;
   assign m_tkeep  = out_keep;
   assign m_tlast  = out_last;

endmodule
